// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter that shares one uart_tx between NUM_REQ
// byte producers, with message locking so multi-byte messages never interleave.
//
// Handshake: a byte moves from requester i at a rising clk edge where
// req_valid[i] & req_ready[i]. req_ready is offered only in IDLE, only while
// the transmitter is free and reset is low, and to at most one requester.
// Requesters hold req_valid, req_data and req_last stable until accepted.
module uart_tx_arb #(
    parameter int NUM_REQ     = 3,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       msg_lock,
    output logic                       ack_err
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(ACK_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        ACK   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [GW-1:0] rr_ptr;
    logic [CW-1:0] ack_cnt;

    // Candidate selection results
    logic          cand_found;
    logic [GW-1:0] cand_idx;
    logic [7:0]    cand_data;
    logic          cand_last;
    logic [GW:0]   scan_pos;

    // FSM-derived strobes
    logic          accept;
    logic          ack_timeout;

    // Successor index with wrap from NUM_REQ-1 back to 0.
    function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] idx);
        if (idx == GW'(NUM_REQ - 1)) begin
            return '0;
        end
        return idx + GW'(1);
    endfunction

    // Pick the requester to serve: the lock owner alone while a message is
    // open, otherwise the first valid requester scanning upward from rr_ptr.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        scan_pos   = '0;
        if (msg_lock) begin
            cand_found = req_valid[grant_id];
            cand_idx   = grant_id;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                scan_pos = {1'b0, rr_ptr} + (GW+1)'(k);
                if (scan_pos >= (GW+1)'(NUM_REQ)) begin
                    scan_pos = scan_pos - (GW+1)'(NUM_REQ);
                end
                if (!cand_found && req_valid[scan_pos[GW-1:0]]) begin
                    cand_found = 1'b1;
                    cand_idx   = scan_pos[GW-1:0];
                end
            end
        end
    end

    // Route the selected requester's byte and last flag.
    always_comb begin
        cand_data = '0;
        cand_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (cand_idx == GW'(i)) begin
                cand_data = req_data[8*i +: 8];
                cand_last = req_last[i];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-state outputs; ACK only leaves on a seen tx_busy
    // or on timeout, so DONE never exits on a stale low tx_busy.
    always_comb begin
        state_next  = state;
        req_ready   = '0;
        tx_start    = 1'b0;
        ack_err     = 1'b0;
        accept      = 1'b0;
        ack_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (!rst && !tx_busy && cand_found) begin
                    accept              = 1'b1;
                    req_ready[cand_idx] = 1'b1;
                    state_next          = START;
                end
            end
            START: begin
                tx_start   = 1'b1;
                state_next = ACK;
            end
            ACK: begin
                if (tx_busy) begin
                    state_next = DONE;
                end else if (ack_cnt == CW'(ACK_TIMEOUT - 1)) begin
                    ack_timeout = 1'b1;
                    ack_err     = 1'b1;
                    state_next  = IDLE;
                end
            end
            DONE: begin
                if (!tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered byte, grant bookkeeping, lock, round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data  <= '0;
            grant_id <= '0;
            msg_lock <= 1'b0;
            rr_ptr   <= '0;
        end else if (accept) begin
            tx_data  <= cand_data;
            grant_id <= cand_idx;
            msg_lock <= ~cand_last;
            if (cand_last) begin
                rr_ptr <= next_idx(cand_idx);
            end
        end else if (ack_timeout) begin
            // Abandon the open message and move priority past its owner.
            msg_lock <= 1'b0;
            rr_ptr   <= next_idx(grant_id);
        end
    end

    // Cycles spent in ACK waiting for the transmitter to report busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_cnt <= '0;
        end else if (state == START) begin
            ack_cnt <= '0;
        end else if (state == ACK && !tx_busy && !ack_timeout) begin
            ack_cnt <= ack_cnt + CW'(1);
        end
    end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin arbiter that shares one uart_tx instance between NUM_REQ byte producers (e.g. the rx echo path, a status reporter, a debug logger).
- Accepts bytes over per-requester valid/ready, issues one tx_start per byte, and tracks tx_busy to know when the transmitter is free again.
- Supports message locking: a requester that asserts req_last=0 keeps the grant until it sends a byte with req_last=1, so multi-byte messages never interleave.
- Sits between the producers and uart_tx, alongside uart_ctrl, in the top-level UART integration.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ACK_TIMEOUT, 16, cycles to wait for tx_busy to rise after tx_start before declaring an ack error (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  requester i has a byte.
- req_data  in  8*NUM_REQ  byte of requester i at [8i+7:8i].
- req_last  in  NUM_REQ  byte of requester i ends its message.
- req_ready  out  NUM_REQ  byte of requester i accepted this cycle (one-hot or zero).
- tx_start  out  1  one-cycle start pulse to uart_tx.
- tx_data  out  8  byte to uart_tx, registered, stable from tx_start until the next acceptance.
- tx_busy  in  1  uart_tx busy flag.
- grant_id  out  clog2(NUM_REQ)  index of the last accepted requester.
- msg_lock  out  1  a message is in progress; only grant_id may be granted.
- ack_err  out  1  one-cycle pulse on ack timeout.

Behaviour:
- Reset (rst=1 at a clock edge, any state):
  - state=IDLE, tx_start=0, tx_data=0, req_ready=0, grant_id=0, msg_lock=0, ack_err=0, rr_ptr=0, timeout counter=0.
  - Reset mid-transfer abandons the byte; tx_busy is not waited on.
- FSM states: IDLE, START, ACK, DONE.
- IDLE:
  - Grant only when tx_busy=0.
  - If msg_lock=1: candidate set is {grant_id}.
  - Otherwise: first valid requester searching upward from rr_ptr, wrapping NUM_REQ-1 -> 0.
  - On grant g:
    - req_ready[g]=1 combinationally in the same cycle; handshake = valid & ready.
    - Register tx_data <= req_data[g] and grant_id <= g.
    - msg_lock <= ~req_last[g].
    - If req_last[g]=1: rr_ptr <= (g+1) mod NUM_REQ; else rr_ptr is unchanged.
    - Next state START.
  - No valid candidate, or tx_busy=1: stay in IDLE, req_ready=0.
- START: tx_start=1 for exactly this cycle; clear timeout counter; go to ACK. Accept-to-tx_start latency is 1 cycle.
- ACK:
  - tx_busy=1 -> DONE.
  - Otherwise increment the counter. When the counter reaches ACK_TIMEOUT-1 without tx_busy: ack_err=1 for one cycle, msg_lock <= 0, rr_ptr <= (grant_id+1) mod NUM_REQ, go to IDLE.
- DONE: wait for tx_busy=0 -> IDLE. Next grant is possible on the following cycle, so the minimum byte spacing is accept / START / ACK / DONE-fall / IDLE.
- req_ready is 0 in every state except IDLE. Requesters must hold req_valid and req_data until ready.
- A locked owner that drops req_valid stalls the arbiter in IDLE indefinitely. Other requesters wait; this is by design.
- A simultaneous request from all requesters resolves strictly by rr_ptr.
- Priority wrap-around: with rr_ptr=NUM_REQ-1, requester NUM_REQ-1 is checked first, then 0, 1, ...
- tx_busy must not be sampled for DONE exit before ACK has seen it high. A glitch-free single-cycle tx_busy high still passes ACK -> DONE -> IDLE.

Test Plan:
- Single byte: req_valid[1]=1, data 0x41, last=1 -> req_ready[1] pulses in IDLE; tx_start 1 cycle later with tx_data=0x41; grant_id=1; rr_ptr=2; msg_lock stays 0.
- Round robin: all three valid, each last=1, model holds tx_busy for 10 cycles per byte -> grant order 0,1,2,0; each byte gets exactly one tx_start.
- Message lock: req0 sends 0x48,0x49 with last=0 then 0x0A with last=1 while req2 stays valid -> bytes 0x48,0x49,0x0A go out before req2's byte; msg_lock=1 from the first acceptance until the 0x0A acceptance.
- Ack timeout: model never raises tx_busy -> ack_err pulses exactly ACK_TIMEOUT cycles after tx_start; msg_lock clears; arbiter returns to IDLE and grants the next requester.
- Busy at idle: tx_busy=1 with req_valid=1 -> no req_ready until tx_busy falls, then grant on the next cycle.
- Reset mid-transfer: assert rst in DONE -> all outputs at reset values on the next cycle; with a pending request, grant resumes from requester 0.
